// File: rtl/lp805x_port_stim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lp805x_port_stim                                                |
// | Purpose  : Command-FIFO sequencer driving lp805x p0_i, int0 and int1.      |
// |            Optional macro LP805X_STIM_SYNC_EN adds a 2-flop p0_out sync.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lp805x_port_stim #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] TIMEOUT    = 16'd50000,
    parameter logic [7:0]  P0_RESET   = 8'hA5
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [10:0] cmd_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        clr_i,
    input  logic [7:0]  p0_out_i,
    output logic [7:0]  p0_i_o,
    output logic        int0_o,
    output logic        int1_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int               c_AW       = $clog2(FIFO_DEPTH);
    localparam logic [c_AW-1:0]  c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]    c_CNT_ONE  = (c_AW+1)'(1);
    localparam logic [c_AW:0]    c_FULL     = (c_AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] c_OP_NOP    = 3'd0;
    localparam logic [2:0] c_OP_SET_P0 = 3'd1;
    localparam logic [2:0] c_OP_PULSE0 = 3'd2;
    localparam logic [2:0] c_OP_PULSE1 = 3'd3;
    localparam logic [2:0] c_OP_WAIT   = 3'd4;
    localparam logic [2:0] c_OP_WAITP0 = 3'd5;
    localparam logic [2:0] c_OP_HALT   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PULSE  = 3'd1,
        S_WAIT   = 3'd2,
        S_WAITP0 = 3'd3,
        S_HALT   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [10:0]       r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic [c_AW:0]     w_count_nxt;
    logic              r_ready;
    logic              w_push;
    logic              w_pop;
    logic [10:0]       w_head;

    logic [15:0]       r_cnt;
    logic [15:0]       w_cnt_nxt;
    logic [16:0]       w_cnt_inc;
    logic [7:0]        r_arg;
    logic [7:0]        w_arg_nxt;
    logic [7:0]        r_p0;
    logic [7:0]        w_p0_nxt;
    logic              r_int0;
    logic              w_int0_nxt;
    logic              r_int1;
    logic              w_int1_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [1:0]        r_code;
    logic [1:0]        w_code_nxt;
    logic [7:0]        w_p0_cmp;

`ifdef LP805X_STIM_SYNC_EN
    logic [7:0] r_p0_meta;
    logic [7:0] r_p0_sync;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_p0_meta <= 8'd0;
            r_p0_sync <= 8'd0;
        end else begin
            r_p0_meta <= p0_out_i;
            r_p0_sync <= r_p0_meta;
        end
    end

    assign w_p0_cmp = r_p0_sync;
`else
    assign w_p0_cmp = p0_out_i;
`endif

    // ready is registered, so a push is only ever taken into a free slot
    assign w_push    = cmd_valid_i && r_ready && !clr_i;
    assign w_pop     = (r_state == S_IDLE) && (r_count != '0) && !clr_i;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

    always_comb begin
        w_count_nxt = r_count;
        if (clr_i) begin
            w_count_nxt = '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + c_CNT_ONE;
                2'b01:   w_count_nxt = r_count - c_CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != c_FULL);
            if (clr_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_arg_nxt   = r_arg;
        w_p0_nxt    = r_p0;
        w_int0_nxt  = r_int0;
        w_int1_nxt  = r_int1;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_code_nxt  = r_code;
        if (clr_i) begin
            w_state_nxt = S_IDLE;
            w_int0_nxt  = 1'b0;
            w_int1_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_code_nxt  = 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        w_arg_nxt = w_head[7:0];
                        case (w_head[10:8])
                            c_OP_NOP: begin
                            end
                            c_OP_SET_P0: w_p0_nxt = w_head[7:0];
                            c_OP_PULSE0, c_OP_PULSE1: begin
                                w_state_nxt = S_PULSE;
                                w_cnt_nxt   = (w_head[7:0] == 8'd0) ? 16'd1 : {8'd0, w_head[7:0]};
                                w_int0_nxt  = (w_head[10:8] == c_OP_PULSE0);
                                w_int1_nxt  = (w_head[10:8] == c_OP_PULSE1);
                            end
                            c_OP_WAIT: begin
                                w_cnt_nxt = {8'd0, w_head[7:0]};
                                if (w_head[7:0] != 8'd0) w_state_nxt = S_WAIT;
                            end
                            c_OP_WAITP0: begin
                                w_state_nxt = S_WAITP0;
                                w_cnt_nxt   = 16'd0;
                            end
                            c_OP_HALT: begin
                                w_state_nxt = S_HALT;
                                w_done_nxt  = 1'b1;
                            end
                            default: begin
                                w_state_nxt = S_ERR;
                                w_err_nxt   = 1'b1;
                                w_code_nxt  = 2'd2;
                            end
                        endcase
                    end
                end
                S_PULSE, S_WAIT: begin
                    if (r_cnt <= 16'd1) begin
                        w_state_nxt = S_IDLE;
                        w_int0_nxt  = 1'b0;
                        w_int1_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                end
                S_WAITP0: begin
                    // counter holds the number of unmatched cycles seen so far
                    if (w_p0_cmp == r_arg) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_cnt_inc >= {1'b0, TIMEOUT}) begin
                        w_state_nxt = S_ERR;
                        w_err_nxt   = 1'b1;
                        w_code_nxt  = 2'd1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc[15:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_cnt  <= 16'd0;
            r_arg  <= 8'd0;
            r_p0   <= P0_RESET;
            r_int0 <= 1'b0;
            r_int1 <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_code <= 2'd0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_arg  <= w_arg_nxt;
            r_p0   <= w_p0_nxt;
            r_int0 <= w_int0_nxt;
            r_int1 <= w_int1_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            r_code <= w_code_nxt;
        end
    end

    assign cmd_ready_o = r_ready;
    assign p0_i_o      = r_p0;
    assign int0_o      = r_int0;
    assign int1_o      = r_int1;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign err_code_o  = r_code;
    assign busy_o      = (r_state == S_PULSE) || (r_state == S_WAIT) || (r_state == S_WAITP0) ||
                         ((r_state == S_IDLE) && (r_count != '0));

endmodule
`default_nettype wire

// File: doc/lp805x_port_stim.md
Name: lp805x_port_stim

Overview:
- Synthesizable stimulus sequencer that drives the lp805x core's inputs: port-0 input bus and the int0/int1 interrupt lines.
- Host side (bench, debug bridge or scan loader) pushes 11-bit commands into an internal FIFO.
- The block executes the commands in order. It can set p0 input values, pulse interrupts, wait a number of cycles, and wait for the core to echo an expected value on p0_out, with a timeout.
- It complements the existing exit-code check on p0_out, which consumes core outputs; this block supplies the core inputs.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, minimum 2.
- TIMEOUT, 16'd50000, WAIT_P0 timeout in clock cycles; 16-bit.
- P0_RESET, 8'hA5, p0_i value at reset.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  asynchronous active-low reset.
- cmd_i  in  11  command {op[10:8], arg[7:0]}.
- cmd_valid_i  in  1  host presents cmd_i.
- cmd_ready_o  out  1  FIFO can accept a command.
- clr_i  in  1  synchronous flush/restart.
- p0_out_i  in  8  core port-0 output (monitored).
- p0_i_o  out  8  drives core p0_i.
- int0_o  out  1  drives core int0_i.
- int1_o  out  1  drives core int1_i.
- busy_o  out  1  a command is executing, or the FIFO is non-empty.
- done_o  out  1  sticky; HALT executed.
- err_o  out  1  sticky; timeout or illegal opcode.
- err_code_o  out  2  0 none, 1 timeout, 2 illegal opcode.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (wb_clk_i, wb_rst_i).
- Reset values: p0_i_o=P0_RESET, int0_o=int1_o=0, cmd_ready_o=1, busy_o=0, done_o=0, err_o=0, err_code_o=0, FIFO empty, FSM=IDLE. Reset mid-operation aborts the current command immediately.
- Push: a command is written when cmd_valid_i&&cmd_ready_o. cmd_ready_o=!full, registered.
  - A push while full is ignored and not stored; the host must hold cmd_i.
  - A pushed entry is poppable no earlier than the next cycle.
- Pop: in IDLE with the FIFO non-empty, the head is popped and decoded in the same cycle. At most one pop per cycle. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Opcodes:
  - 0 NOP: no effect; return to IDLE.
  - 1 SET_P0: p0_i_o<=arg, visible the cycle after pop.
  - 2 PULSE0: int0_o=1 for max(arg,1) cycles, starting the cycle after pop.
  - 3 PULSE1: the same, on int1_o.
  - 4 WAIT: stay arg cycles in WAIT; arg=0 returns to IDLE next cycle.
  - 5 WAIT_P0: compare p0_out_i==arg every cycle.
    - Match: return to IDLE the next cycle.
    - Cycle counter reaches TIMEOUT with no match: go to ERR, err_code_o=1.
  - 6 HALT: go to HALT; done_o=1.
  - 7 illegal: go to ERR, err_code_o=2.
- FSM states: IDLE, PULSE, WAIT, WAITP0, HALT, ERR.
  - PULSE, WAIT and WAITP0 return to IDLE.
  - HALT and ERR are terminal until clr_i. No pops occur in HALT or ERR; pushes are still accepted while the FIFO is not full.
- Counters: one 16-bit down/up counter shared by PULSE, WAIT and WAITP0; reloaded on every pop. No wrap-around: WAITP0 saturates at TIMEOUT.
- clr_i, one cycle, in any state:
  - Next cycle: FSM=IDLE, FIFO flushed, done_o=err_o=0, err_code_o=0, int0_o=int1_o=0.
  - p0_i_o is retained.
  - clr_i has priority over a simultaneous push (the push is discarded) and over a simultaneous pop.
- busy_o is 1 whenever FSM is not IDLE/HALT/ERR, or the FIFO is non-empty while in IDLE.

Optional Feature:
- Macro: LP805X_STIM_SYNC_EN.
- Defined: p0_out_i passes through a two-flop synchronizer before the WAIT_P0 compare. Match detection is delayed by 2 cycles. The timeout count is unchanged.
- Undefined: p0_out_i is compared directly, same cycle.

Test Plan:
- Reset with wb_rst_i=0 -> p0_i_o=8'hA5, int0_o=int1_o=0, cmd_ready_o=1, busy_o=0. Release, push {1,8'h3C} -> p0_i_o=8'h3C exactly 2 cycles after the push cycle.
- Push {2,8'd0} then {3,8'd4} -> int0_o high for 1 cycle, then int1_o high for 4 consecutive cycles; never both high together.
- Push {5,8'd127}, drive p0_out_i=8'hFF, then 8'd127 at cycle 20 -> FSM leaves WAITP0 at cycle 21 (23 with LP805X_STIM_SYNC_EN), err_o=0.
- Push {5,8'h7F} with p0_out_i held at 8'hFF (TIMEOUT=100 override) -> err_o=1, err_code_o=1 after 100 cycles. Assert clr_i -> err_o=0, FIFO empty, p0_i_o retained.
- Push FIFO_DEPTH+1 commands behind a {4,8'd255} -> cmd_ready_o=0 once full, the extra push is not stored; ready reasserts on the first pop. Queue {7,0} -> err_code_o=2. Queue {6,0} -> done_o=1, busy_o=0.
- Assert wb_rst_i mid-PULSE0 -> int0_o=0 immediately (asynchronous), all outputs at reset values.
